// File: rtl/mux8_arb_pkg.sv
// Shared types, constants and the rotating priority encoder for mux8_rr_arbiter.
package mux8_arb_pkg;

    localparam int unsigned NREQ  = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic [0:0] {
        IDLE,
        GRANT
    } arb_state_e;

    // First set request bit at or after base, scanning upward with wrap.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NREQ-1:0]  r,
                                                 input logic [SEL_W-1:0] base);
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] result;
        logic             found;
        result = base;
        found  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = base + SEL_W'(i);
            if (!found && r[idx]) begin
                result = idx;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mux8.sv
// Plain 8:1 single-bit multiplexer.
module mux8
    import mux8_arb_pkg::*;
(
    input  logic [NREQ-1:0]  data,
    input  logic [SEL_W-1:0] sel,
    output logic             y
);

    assign y = data[sel];

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin 8-way arbiter with per-grant hold limit, steering data[sel] to out.
// Optional MUX8_ARB_LOCK_EN adds a lock input that suspends the hold limit.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  data,
`ifdef MUX8_ARB_LOCK_EN
    input  logic [NREQ-1:0]  lock,
`endif
    output logic [NREQ-1:0]  gnt,
    output logic [SEL_W-1:0] sel,
    output logic             valid,
    output logic             out
);

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [3:0]       hold_q, hold_d;

    logic [SEL_W-1:0] next_ptr;
    logic [SEL_W-1:0] winner;
    logic             hold_limit;
    logic             release_now;
    logic             mux_y;

    assign next_ptr = sel_q + 3'd1;

`ifdef MUX8_ARB_LOCK_EN
    assign hold_limit = (hold_q == HOLD_LAST) && !lock[sel_q];
`else
    assign hold_limit = (hold_q == HOLD_LAST);
`endif

    assign release_now = !req[sel_q] || hold_limit;

    // On release the scan starts just past the current owner, so it wins again only when alone.
    assign winner = rr_pick(req, (state_q == GRANT) ? next_ptr : ptr_q);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d        = GRANT;
                    sel_d          = winner;
                    gnt_d          = '0;
                    gnt_d[winner]  = 1'b1;
                    hold_d         = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d  = next_ptr;
                    hold_d = '0;
                    if (|req) begin
                        sel_d         = winner;
                        gnt_d         = '0;
                        gnt_d[winner] = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (hold_q != HOLD_LAST) begin
                    // Saturates while locked so the limit fires as soon as lock drops.
                    hold_d = hold_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            hold_q  <= hold_d;
        end
    end

    mux8 u_mux8 (
        .data (data),
        .sel  (sel_q),
        .y    (mux_y)
    );

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = (state_q == GRANT);
    assign out   = valid & mux_y;

endmodule

// File: doc/mux8_rr_arbiter.md
MUX8_RR_ARBITER -- requirements
Module: mux8_rr_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 4, which is the maximum consecutive grant cycles per requester (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req, input, 8 bits: request from requester i on bit i.
REQ-005 SHALL have port data, input, 8 bits: data bit offered by requester i on bit i.
REQ-006 SHALL have port gnt, output, 8 bits: one-hot grant, registered.
REQ-007 SHALL have port sel, output, 3 bits: binary index of the granted requester, registered.
REQ-008 SHALL have port valid, output, 1 bit: high when a grant is active.
REQ-009 SHALL have port out, output, 1 bit: data[sel] when valid is high, 0 otherwise (combinational from registered sel).

Function
REQ-010 SHALL implement two states, IDLE and GRANT.
REQ-011 In IDLE with req==0, SHALL stay in IDLE; gnt=0, valid=0.
REQ-012 In IDLE with req!=0, SHALL select the winner as the first set req bit at or after ptr, scanning upward with 7->0 wrap, and enter GRANT next cycle with gnt/sel/valid set (1-cycle req-to-grant latency).
REQ-013 In GRANT, hold counter SHALL start at 0 and increment by 1 each cycle the grant is held.
REQ-014 Release SHALL occur when req[sel]==0, or when hold counter == MAX_HOLD-1 (grant lasts at most MAX_HOLD cycles).
REQ-015 On release, ptr SHALL become sel+1 mod 8.
REQ-016 On release, the next winner SHALL be arbitrated in the same cycle from the new ptr, with no idle gap.
REQ-017 The releasing requester SHALL win again only if its req is still high and no other req bit is set.
REQ-018 On release with no eligible request, SHALL go to IDLE; gnt=0, valid=0, and sel holds its last value.
REQ-019 gnt SHALL always be zero or one-hot and SHALL equal (valid << sel).
REQ-020 req changes on non-granted bits SHALL NOT affect the current grant.

Reset
REQ-021 While rst_n==0, SHALL force: state=IDLE, gnt=0, sel=0, valid=0, out=0, ptr=0, hold counter=0.
REQ-022 Reset assertion mid-GRANT SHALL drop the grant immediately (asynchronously).
REQ-023 The first arbitration after reset release SHALL start from ptr=0.

Configuration
REQ-024 Macro MUX8_ARB_LOCK_EN defined: SHALL add input lock, 8 bits; while lock[sel]==1 in GRANT, the MAX_HOLD limit is ignored and the grant holds until req[sel] drops.
REQ-025 Macro MUX8_ARB_LOCK_EN undefined: SHALL have no lock port, and the MAX_HOLD limit always applies.

Structure
REQ-026 A shared package mux8_arb_pkg SHALL hold the state enum (IDLE, GRANT), the constant NREQ=8 and the constant SEL_W=3.
REQ-027 SHALL instantiate the team's existing mux8 as its one sub-module for the data-to-out path, with data=data and sel=sel, gated by valid.
REQ-028 The rotating priority encoder SHALL be a function in mux8_arb_pkg, not a separate module.

Verification
REQ-029 Reset then req=8'h00 for 5 cycles -> gnt=0, valid=0, out=0 throughout.
REQ-030 req=8'h10 held, data=8'h10, MAX_HOLD=4 -> cycle+1: gnt=8'h10, sel=4, out=1; gnt held exactly 4 cycles, then 8'h10 again (sole requester).
REQ-031 req=8'h81 held, ptr=0 -> grants alternate 0 (4 cycles), 7 (4 cycles), 0, with no gap cycles.
REQ-032 Requester 2 granted, drops req after 2 cycles while req[5]=1 -> next cycle gnt=8'h20, sel=5.
REQ-033 rst_n pulsed low mid-grant of requester 6 -> gnt=0 and valid=0 immediately; after release, req=8'hC0 -> grant goes to 6 (ptr=0).
REQ-034 With MUX8_ARB_LOCK_EN defined, req=8'h03 and lock=8'h01 for 10 cycles -> requester 0 held 10 cycles, then requester 1 granted.
